// File: rtl/dist_calc_if.sv
// Element-fetch handshake and result bus of the trace/distance engine.
// master = the engine, slave = the requester plus matrix storage.
interface dist_calc_if #(
  parameter int N = 2,
  parameter int W = 19,
  parameter int F = 17
);
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2*W + 1 - F + $clog2(N*N);
  localparam int OUT_W = 2*ACC_W + 1 - F;

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    el_valid;
  logic [IW-1:0]           el_row;
  logic [IW-1:0]           el_col;
  logic signed [W-1:0]     a_re;
  logic signed [W-1:0]     a_im;
  logic signed [W-1:0]     b_re;
  logic signed [W-1:0]     b_im;
  logic signed [ACC_W-1:0] tr_re;
  logic signed [ACC_W-1:0] tr_im;
  logic [OUT_W-1:0]        dist2;

  modport master (
    input  start, a_re, a_im, b_re, b_im,
    output busy, done, el_valid, el_row, el_col, tr_re, tr_im, dist2
  );

  modport slave (
    output start, a_re, a_im, b_re, b_im,
    input  busy, done, el_valid, el_row, el_col, tr_re, tr_im, dist2
  );
endinterface

// File: rtl/dist_calc_seq.sv
// Sequential trace(A^H*B) and |T|^2 engine: one element pair per cycle,
// a single complex multiplier for the MAC and two squarers for the magnitude.
//
// state  | meaning
// IDLE   | waiting for start; results held
// FETCH  | presenting element indices row-major, one per cycle
// DRAIN  | absorbing the response to the last index
// SQUARE | latching trace and |T|^2; done pulses next cycle
module dist_calc_seq #(
  parameter int N = 2,
  parameter int W = 19,
  parameter int F = 17
) (
  input  logic         clk,
  input  logic         reset,
  dist_calc_if.master  bus
);
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2*W + 1 - F + $clog2(N*N);
  localparam int OUT_W = 2*ACC_W + 1 - F;
  localparam int PW    = 2*W + 1;
  localparam int TW    = PW - F;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, SQUARE} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   busy_nxt, el_valid_nxt;
  logic   last_idx;

  logic                    busy_q, el_valid_q, done_q, rsp_valid;
  logic [IW-1:0]           row, col;
  logic signed [ACC_W-1:0] acc_re, acc_im;
  logic signed [ACC_W-1:0] tr_re_q, tr_im_q;
  logic [OUT_W-1:0]        dist2_q;

  logic signed [2*W-1:0]     p_rr, p_ii, p_ri, p_ir;
  logic signed [PW-1:0]      s_re, s_im;
  logic signed [ACC_W-1:0]   term_re, term_im;
  logic signed [2*ACC_W-1:0] sq_re, sq_im;
  logic [2*ACC_W:0]          mag;
  logic [OUT_W-1:0]          dist2_nxt;

  assign last_idx = (row == IW'(N-1)) && (col == IW'(N-1));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = FETCH;
          accept    = 1'b1;
        end
      end
      FETCH:   if (last_idx) state_nxt = DRAIN;
      DRAIN:   state_nxt = SQUARE;
      SQUARE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt     = (state_nxt != IDLE);
    el_valid_nxt = (state_nxt == FETCH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q     <= 1'b0;
      el_valid_q <= 1'b0;
      done_q     <= 1'b0;
      rsp_valid  <= 1'b0;
      row        <= '0;
      col        <= '0;
    end else begin
      busy_q     <= busy_nxt;
      el_valid_q <= el_valid_nxt;
      done_q     <= (state == SQUARE);
      rsp_valid  <= el_valid_q;
      if (accept || (state == FETCH && last_idx)) begin
        row <= '0;
        col <= '0;
      end else if (state == FETCH) begin
        if (col == IW'(N-1)) begin
          col <= '0;
          row <= row + IW'(1);
        end else begin
          col <= col + IW'(1);
        end
      end
    end
  end

  // Full-precision complex product of conj(a) and b.
  assign p_rr = (2*W)'(bus.a_re) * (2*W)'(bus.b_re);
  assign p_ii = (2*W)'(bus.a_im) * (2*W)'(bus.b_im);
  assign p_ri = (2*W)'(bus.a_re) * (2*W)'(bus.b_im);
  assign p_ir = (2*W)'(bus.a_im) * (2*W)'(bus.b_re);
  assign s_re = PW'(p_rr) + PW'(p_ii);
  assign s_im = PW'(p_ri) - PW'(p_ir);

  // Dropping the low F bits of a two's-complement sum is a floor shift.
  assign term_re = {{(ACC_W-TW){s_re[PW-1]}}, s_re[PW-1:F]};
  assign term_im = {{(ACC_W-TW){s_im[PW-1]}}, s_im[PW-1:F]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (accept) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (rsp_valid) begin
      acc_re <= acc_re + term_re;
      acc_im <= acc_im + term_im;
    end
  end

  // Squares are non-negative, so the sum is taken unsigned with one carry bit.
  assign sq_re     = (2*ACC_W)'(acc_re) * (2*ACC_W)'(acc_re);
  assign sq_im     = (2*ACC_W)'(acc_im) * (2*ACC_W)'(acc_im);
  assign mag       = {1'b0, sq_re} + {1'b0, sq_im};
  assign dist2_nxt = mag[2*ACC_W:F];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tr_re_q <= '0;
      tr_im_q <= '0;
      dist2_q <= '0;
    end else if (state == SQUARE) begin
      tr_re_q <= acc_re;
      tr_im_q <= acc_im;
      dist2_q <= dist2_nxt;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.el_valid = el_valid_q;
  assign bus.done     = done_q;
  assign bus.el_row   = row;
  assign bus.el_col   = col;
  assign bus.tr_re    = tr_re_q;
  assign bus.tr_im    = tr_im_q;
  assign bus.dist2    = dist2_q;
endmodule

// File: tb/tb_dist_calc_seq.sv
// Directed bench for dist_calc_seq at N=2 (handshake, rounding, reset) and
// N=3 (random elements against a longint reference).
module tb_dist_calc_seq;
  localparam int W   = 19;
  localparam int F   = 17;
  localparam int ONE = 131072;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dist_calc_if #(.N(2), .W(W), .F(F)) bus2();
  dist_calc_if #(.N(3), .W(W), .F(F)) bus3();

  dist_calc_seq #(.N(2), .W(W), .F(F)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  dist_calc_seq #(.N(3), .W(W), .F(F)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  int errors = 0;
  int checks = 0;

  int ar2[4], ai2[4], br2[4], bi2[4];
  int ar3[9], ai3[9], br3[9], bi3[9];

  logic [15:0] evm, bm, dm;
  int          bad_idx, held_bad;
  logic signed [63:0] first_re;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Storage model: answer in the cycle after each request, noise otherwise.
  logic rv2, rv3;
  int   ri2, ri3;
  always @(posedge clk) begin
    rv2 = bus2.el_valid;
    ri2 = int'(bus2.el_row) * 2 + int'(bus2.el_col);
    #1;
    if (rv2) begin
      bus2.a_re = W'(ar2[ri2]); bus2.a_im = W'(ai2[ri2]);
      bus2.b_re = W'(br2[ri2]); bus2.b_im = W'(bi2[ri2]);
    end else begin
      bus2.a_re = W'($urandom); bus2.a_im = W'($urandom);
      bus2.b_re = W'($urandom); bus2.b_im = W'($urandom);
    end
  end

  always @(posedge clk) begin
    rv3 = bus3.el_valid;
    ri3 = int'(bus3.el_row) * 3 + int'(bus3.el_col);
    #1;
    if (rv3) begin
      bus3.a_re = W'(ar3[ri3]); bus3.a_im = W'(ai3[ri3]);
      bus3.b_re = W'(br3[ri3]); bus3.b_im = W'(bi3[ri3]);
    end else begin
      bus3.a_re = W'($urandom); bus3.a_im = W'($urandom);
      bus3.b_re = W'($urandom); bus3.b_im = W'($urandom);
    end
  end

  // A = a*I, B = b*I
  task automatic set_diag2(input int a_r, input int a_i, input int b_r, input int b_i);
    for (int k = 0; k < 4; k++) begin
      ar2[k] = 0; ai2[k] = 0; br2[k] = 0; bi2[k] = 0;
    end
    ar2[0] = a_r; ar2[3] = a_r; ai2[0] = a_i; ai2[3] = a_i;
    br2[0] = b_r; br2[3] = b_r; bi2[0] = b_i; bi2[3] = b_i;
  endtask

  // One N=2 operation, observed for cycles 1..15 after the start cycle.
  task automatic run2(input bit dup, input bit chain);
    int k;
    evm = '0; bm = '0; dm = '0; bad_idx = 0; held_bad = 0; k = 0; first_re = '0;
    @(posedge clk); #1 bus2.start = 1'b1;
    @(posedge clk); #1 bus2.start = 1'b0;
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      if (dup)   bus2.start = (c == 3);
      if (chain) bus2.start = (c == 7);
      if (chain && c == 7) begin
        first_re = 64'($signed(bus2.tr_re));
        set_diag2(ONE, 0, -ONE, 0);
      end
      if (chain && c >= 8 && c <= 13 && 64'($signed(bus2.tr_re)) != first_re)
        held_bad++;
      evm[c] = bus2.el_valid;
      bm[c]  = bus2.busy;
      dm[c]  = bus2.done;
      if (bus2.el_valid) begin
        if (int'(bus2.el_row) * 2 + int'(bus2.el_col) != (k % 4)) bad_idx++;
        k++;
      end
    end
    bus2.start = 1'b0;
  endtask

  task automatic check_res2(input string tag, input longint e_re, input longint e_im,
                            input longint e_d2);
    check_val({tag, " tr_re"}, 64'($signed(bus2.tr_re)), e_re);
    check_val({tag, " tr_im"}, 64'($signed(bus2.tr_im)), e_im);
    check_val({tag, " dist2"}, {32'd0, bus2.dist2}, e_d2);
  endtask

  task automatic check_timing2(input string tag);
    check_val({tag, " el_valid cycles"}, {48'd0, evm}, 64'h001E);
    check_val({tag, " busy cycles"},     {48'd0, bm},  64'h007E);
    check_val({tag, " done cycles"},     {48'd0, dm},  64'h0080);
    check_val({tag, " index order"},     bad_idx, 0);
  endtask

  task automatic run3(input string tag);
    longint sre, sim, d2;
    int done_cyc, ndone;
    sre = 0; sim = 0;
    for (int k = 0; k < 9; k++) begin
      sre += (longint'(ar3[k]) * br3[k] + longint'(ai3[k]) * bi3[k]) >>> F;
      sim += (longint'(ar3[k]) * bi3[k] - longint'(ai3[k]) * br3[k]) >>> F;
    end
    d2 = (sre * sre + sim * sim) >>> F;
    @(posedge clk); #1 bus3.start = 1'b1;
    @(posedge clk); #1 bus3.start = 1'b0;
    done_cyc = -1; ndone = 0;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (bus3.done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    check_val({tag, " done cycle"}, done_cyc, 12);
    check_val({tag, " done count"}, ndone, 1);
    check_val({tag, " tr_re"}, 64'($signed(bus3.tr_re)), sre);
    check_val({tag, " tr_im"}, 64'($signed(bus3.tr_im)), sim);
    check_val({tag, " dist2"}, {28'd0, bus3.dist2}, d2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    bus2.start = 1'b0;
    bus3.start = 1'b0;
    set_diag2(0, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      ar3[k] = 0; ai3[k] = 0; br3[k] = 0; bi3[k] = 0;
    end
    repeat (3) @(negedge clk);
    check_val("reset busy",     bus2.busy, 0);
    check_val("reset el_valid", bus2.el_valid, 0);
    check_val("reset done",     bus2.done, 0);
    check_val("reset tr_re",    64'($signed(bus2.tr_re)), 0);
    check_val("reset dist2",    {32'd0, bus2.dist2}, 0);
    reset = 1'b1;

    set_diag2(ONE, 0, ONE, 0);
    run2(1'b0, 1'b0);
    check_timing2("I.I");
    check_res2("I.I", 262144, 0, 524288);

    set_diag2(ONE, 0, -ONE, 0);
    run2(1'b0, 1'b0);
    check_res2("I.-I", -262144, 0, 524288);

    set_diag2(ONE, 0, 0, ONE);
    run2(1'b0, 1'b0);
    check_res2("I.iI", 0, 262144, 524288);

    set_diag2(0, 0, 0, 0);
    ar2[0] = -1; br2[0] = 1;
    run2(1'b0, 1'b0);
    check_res2("floor neg", -1, 0, 0);

    ar2[0] = 1;
    run2(1'b0, 1'b0);
    check_res2("floor pos", 0, 0, 0);

    set_diag2(ONE, 0, ONE, 0);
    run2(1'b1, 1'b0);
    check_timing2("dup start");
    check_res2("dup start", 262144, 0, 524288);

    set_diag2(ONE, 0, ONE, 0);
    run2(1'b0, 1'b1);
    check_val("chain el_valid cycles", {48'd0, evm}, 64'h0F1E);
    check_val("chain busy cycles",     {48'd0, bm},  64'h3F7E);
    check_val("chain done cycles",     {48'd0, dm},  64'h4080);
    check_val("chain index order",     bad_idx, 0);
    check_val("chain first tr_re",     first_re, 262144);
    check_val("chain held result",     held_bad, 0);
    check_res2("chain second", -262144, 0, 524288);

    // Abort in cycle 3 of an operation that follows a non-zero result.
    @(posedge clk); #1 bus2.start = 1'b1;
    @(posedge clk); #1 bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("abort busy",     bus2.busy, 0);
    check_val("abort el_valid", bus2.el_valid, 0);
    check_val("abort done",     bus2.done, 0);
    check_res2("abort", 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    dm = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      dm[c] = bus2.done;
    end
    check_val("abort no done", {48'd0, dm}, 0);

    set_diag2(ONE, 0, 0, ONE);
    run2(1'b0, 1'b0);
    check_timing2("after abort");
    check_res2("after abort", 0, 262144, 524288);

    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 9; k++) begin
        ar3[k] = int'($urandom_range(524287, 0)) - 262144;
        ai3[k] = int'($urandom_range(524287, 0)) - 262144;
        br3[k] = int'($urandom_range(524287, 0)) - 262144;
        bi3[k] = int'($urandom_range(524287, 0)) - 262144;
        if (it == 2) begin
          ar3[k] = -262144; ai3[k] = -262144; br3[k] = -262144; bi3[k] = -262144;
        end
      end
      if (it == 0) begin
        ar3[0] = -262144; br3[0] = -262144;
        ai3[4] = -262144; bi3[4] = 262143;
        br3[8] = 262143;  ai3[8] = -262144;
      end
      run3($sformatf("N3 run%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
